// File: rtl/addsub_sched_pkg.sv
// Shared types and helpers for the add/sub round-robin scheduler.
// Holds the tag type, op encodings and the id-width helper.
package addsub_sched_pkg;

  localparam int ID_W_MAX = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } tag_t;

endpackage

// File: rtl/addsub_rr_scheduler_arb.sv
// rr_arbiter: round-robin pick over an eligible vector, owns the pointer.
// Ports: clk, rst (async low), i_elig in; o_grant one-hot, o_idx, o_any out.
module rr_arbiter
  import addsub_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_elig,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;
  logic [IW-1:0] w_idx;
  logic          w_any;

  // Walk from the farthest candidate to the nearest so the
  // last hit (closest to ptr+1) wins.
  always_comb begin
    w_sum  = '0;
    w_cand = '0;
    w_idx  = '0;
    w_any  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      end
      w_cand = w_sum[IW-1:0];
      if (i_elig[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (w_any) begin
      o_grant = NUM_REQ'(1) << w_idx;
    end
  end

  assign o_idx = w_idx;
  assign o_any = w_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= IW'(NUM_REQ - 1);
    end else if (w_any) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Shares one pipelined add/sub unit among NUM_REQ requesters, round-robin.
// Ports: req_* channels in, add_* to/from adder, rsp_* results, err_sync.
module addsub_rr_scheduler
  import addsub_sched_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int DATAWIDTH       = 8,
  parameter int ADDER_LATENCY   = 4,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]           req_op,
  output logic [DATAWIDTH-1:0]         add_a,
  output logic [DATAWIDTH-1:0]         add_b,
  output logic                         add_op,
  output logic                         add_i_valid,
  input  logic [DATAWIDTH-1:0]         add_result,
  input  logic                         add_carry,
  input  logic                         add_o_valid,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATAWIDTH-1:0]         rsp_result,
  output logic                         rsp_carry,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         err_sync
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TL = ADDER_LATENCY;

  logic [CW-1:0]        r_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_grant;
  logic [NUM_REQ-1:0]   w_dec;
  logic [IW-1:0]        w_idx;
  logic                 w_any;

  logic [DATAWIDTH-1:0] w_a;
  logic [DATAWIDTH-1:0] w_b;
  logic                 w_op;

  logic [DATAWIDTH-1:0] r_add_a;
  logic [DATAWIDTH-1:0] r_add_b;
  logic                 r_add_op;
  logic                 r_add_v;

  tag_t                 r_tag [TL+1];
  tag_t                 w_fin;

  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DATAWIDTH-1:0] r_rsp_result;
  logic                 r_rsp_carry;
  logic [IW-1:0]        r_rsp_id;
  logic                 r_err;

  // Eligibility uses the pre-edge count, so a requester at the cap
  // is not re-granted in the cycle its response frees a slot.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid[i]
               && (r_cnt[i] < CW'(MAX_OUTSTANDING));
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_elig  (w_elig),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Ready is masked while reset is held so no handshake is seen.
  assign req_ready = w_grant & {NUM_REQ{rst}};

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = OP_ADD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a  = req_a[i*DATAWIDTH +: DATAWIDTH];
        w_b  = req_b[i*DATAWIDTH +: DATAWIDTH];
        w_op = req_op[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_add_a  <= '0;
      r_add_b  <= '0;
      r_add_op <= OP_ADD;
      r_add_v  <= 1'b0;
    end else begin
      r_add_v <= w_any;
      if (w_any) begin
        r_add_a  <= w_a;
        r_add_b  <= w_b;
        r_add_op <= w_op;
      end
    end
  end

  // Tag pipe: stage TL lines up with add_o_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s <= TL; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[0].valid <= w_any;
      r_tag[0].id    <= ID_W_MAX'(w_idx);
      for (int s = 1; s <= TL; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  assign w_fin = r_tag[TL];

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dec[i] = w_fin.valid
              && (w_fin.id == ID_W_MAX'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_id     <= '0;
    end else begin
      r_rsp_valid <= w_dec;
      if (w_fin.valid) begin
        r_rsp_result <= add_result;
        r_rsp_carry  <= add_carry;
        r_rsp_id     <= w_fin.id[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else if (!w_grant[i] && w_dec[i]
                     && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_fin.valid != add_o_valid) begin
      r_err <= 1'b1;
    end
  end

  assign add_a       = r_add_a;
  assign add_b       = r_add_b;
  assign add_op      = r_add_op;
  assign add_i_valid = r_add_v;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_carry   = r_rsp_carry;
  assign rsp_id      = r_rsp_id;
  assign err_sync    = r_err;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed bench for addsub_rr_scheduler with a small pipelined adder model.
// Scenarios: reset, add, sub, round-robin, cap, err_sync, mid-flight reset.
module tb_addsub_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int L  = 4;
  localparam int MO = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]  req_op;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic          add_op;
  logic          add_i_valid;
  logic [DW-1:0] add_result;
  logic          add_carry;
  logic          add_o_valid;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_result;
  logic          rsp_carry;
  logic [1:0]    rsp_id;
  logic          err_sync;
  logic          force_ov;

  int checks = 0;
  int errors = 0;

  addsub_rr_scheduler #(
    .NUM_REQ(N), .DATAWIDTH(DW),
    .ADDER_LATENCY(L), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .add_a(add_a), .add_b(add_b), .add_op(add_op),
    .add_i_valid(add_i_valid),
    .add_result(add_result), .add_carry(add_carry),
    .add_o_valid(add_o_valid),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_id(rsp_id),
    .err_sync(err_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: L-stage pipe; subtract carry = 1 means no borrow.
  logic [DW-1:0] m_res [L];
  logic          m_c   [L];
  logic          m_v   [L];
  logic [DW:0]   m_sum;

  always_comb begin
    if (add_op)
      m_sum = {1'b0, add_a} + {1'b0, ~add_b} + 9'd1;
    else
      m_sum = {1'b0, add_a} + {1'b0, add_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < L; k++) begin
        m_v[k]   <= 1'b0;
        m_res[k] <= '0;
        m_c[k]   <= 1'b0;
      end
    end else begin
      m_v[0]   <= add_i_valid;
      m_res[0] <= m_sum[DW-1:0];
      m_c[0]   <= m_sum[DW];
      for (int k = 1; k < L; k++) begin
        m_v[k]   <= m_v[k-1];
        m_res[k] <= m_res[k-1];
        m_c[k]   <= m_c[k-1];
      end
    end
  end

  assign add_result  = m_res[L-1];
  assign add_carry   = m_c[L-1];
  assign add_o_valid = m_v[L-1] | force_ov;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    force_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset_ready: got %h expected 0", req_ready);
    end
    checks++;
    if (add_i_valid !== 1'b0 || add_a !== 8'h00 || add_b !== 8'h00
        || add_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_issue: got v=%b a=%h b=%h op=%b expected 0",
               add_i_valid, add_a, add_b, add_op);
    end
    checks++;
    if (rsp_valid !== 4'h0) begin
      errors++;
      $display("FAIL reset_rsp_valid: got %h expected 0", rsp_valid);
    end
    checks++;
    if (rsp_result !== 8'h00 || rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_rsp_data: got r=%h c=%b id=%0d expected 0",
               rsp_result, rsp_carry, rsp_id);
    end
    checks++;
    if (err_sync !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", err_sync);
    end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_single(input int id, input logic [7:0] a,
                            input logic [7:0] b, input logic op,
                            input logic [7:0] er, input logic ec,
                            input string nm);
    int k;
    @(posedge clk); #1;
    req_a[id*DW +: DW] = a;
    req_b[id*DW +: DW] = b;
    req_op[id] = op;
    req_valid = 4'b0001 << id;
    @(negedge clk);
    checks++;
    if (req_ready !== (4'b0001 << id)) begin
      errors++;
      $display("FAIL %s_ready: got %b expected %b", nm, req_ready,
               4'b0001 << id);
    end
    @(posedge clk); #1;
    req_valid = '0;
    k = 1;
    while (k < 12) begin
      @(negedge clk);
      if (rsp_valid !== 4'h0) break;
      @(posedge clk);
      k++;
    end
    checks++;
    if (k != 6) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected 6", nm, k);
    end
    checks++;
    if (rsp_valid !== (4'b0001 << id) || rsp_id !== 2'(id)) begin
      errors++;
      $display("FAIL %s_dest: got v=%b id=%0d expected v=%b id=%0d",
               nm, rsp_valid, rsp_id, 4'b0001 << id, id);
    end
    checks++;
    if (rsp_result !== er || rsp_carry !== ec) begin
      errors++;
      $display("FAIL %s_result: got %h/%b expected %h/%b",
               nm, rsp_result, rsp_carry, er, ec);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_add();
    run_single(0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "add0");
  endtask

  task automatic test_sub();
    run_single(2, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, "sub_borrow");
    run_single(2, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, "sub_noborrow");
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_res [4];
    logic       exp_c   [4];
    int j;
    exp_res = '{8'h11, 8'h22, 8'h33, 8'h3C};
    exp_c   = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    req_a  = {8'h40, 8'h30, 8'h20, 8'h10};
    req_b  = {8'h04, 8'h03, 8'h02, 8'h01};
    req_op = 4'b1000;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (req_ready !== (4'b0001 << (c % 4))) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got %b expected %b",
                   c, req_ready, 4'b0001 << (c % 4));
        end
      end
      if (c >= 6) begin
        j = (c - 6) % 4;
        checks++;
        if (rsp_valid !== (4'b0001 << j) || rsp_id !== 2'(j)
            || rsp_result !== exp_res[j] || rsp_carry !== exp_c[j]) begin
          errors++;
          $display("FAIL rr_rsp[%0d]: got v=%b id=%0d r=%h c=%b expected v=%b id=%0d r=%h c=%b",
                   c, rsp_valid, rsp_id, rsp_result, rsp_carry,
                   4'b0001 << j, j, exp_res[j], exp_c[j]);
        end
      end else begin
        checks++;
        if (rsp_valid !== 4'h0) begin
          errors++;
          $display("FAIL rr_early_rsp[%0d]: got %b expected 0",
                   c, rsp_valid);
        end
      end
    end
    req_op = '0;
  endtask

  task automatic test_cap();
    int acc;
    int rsp;
    logic [3:0] exp_rdy;
    acc = 0;
    rsp = 0;
    do_reset();
    req_a[1*DW +: DW] = 8'h01;
    req_b[1*DW +: DW] = 8'h01;
    req_op[1] = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 16) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (rsp_valid[1]) rsp++;
      if (req_ready[1]) acc++;
      if (c < 16) begin
        exp_rdy = ((c % 6) < 3) ? 4'b0010 : 4'b0000;
        checks++;
        if (req_ready !== exp_rdy) begin
          errors++;
          $display("FAIL cap_ready[%0d]: got %b expected %b",
                   c, req_ready, exp_rdy);
        end
      end
    end
    checks++;
    if (acc != 9 || rsp != 9) begin
      errors++;
      $display("FAIL cap_totals: got acc=%0d rsp=%0d expected 9/9",
               acc, rsp);
    end
  endtask

  task automatic test_err_sync();
    do_reset();
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (err_sync !== 1'b0) begin
      errors++;
      $display("FAIL err_idle: got %b expected 0", err_sync);
    end
    @(posedge clk); #1;
    force_ov = 1'b1;
    @(negedge clk);
    checks++;
    if (err_sync !== 1'b0) begin
      errors++;
      $display("FAIL err_early: got %b expected 0", err_sync);
    end
    @(posedge clk); #1;
    force_ov = 1'b0;
    @(negedge clk);
    checks++;
    if (err_sync !== 1'b1 || rsp_valid !== 4'h0) begin
      errors++;
      $display("FAIL err_set: got err=%b v=%b expected 1/0",
               err_sync, rsp_valid);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err_sync !== 1'b1 || rsp_valid !== 4'h0) begin
      errors++;
      $display("FAIL err_sticky: got err=%b v=%b expected 1/0",
               err_sync, rsp_valid);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++;
    if (err_sync !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", err_sync);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset_midflight();
    int stale;
    stale = 0;
    do_reset();
    req_a[0 +: DW] = 8'h11;
    req_b[0 +: DW] = 8'h22;
    req_op[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req_valid = 4'b0001;
    end
    @(posedge clk); #1;
    req_valid = 4'hF;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'h0 || add_i_valid !== 1'b0
        || add_a !== 8'h00 || add_b !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_issue: got rdy=%b v=%b a=%h b=%h expected 0",
               req_ready, add_i_valid, add_a, add_b);
    end
    checks++;
    if (rsp_valid !== 4'h0 || err_sync !== 1'b0 || rsp_result !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_rsp: got v=%b err=%b r=%h expected 0",
               rsp_valid, err_sync, rsp_result);
    end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'h0 || err_sync !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL mid_reset_stale: got %0d bad cycles expected 0",
               stale);
    end
    @(posedge clk); #1;
    req_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_first: got %b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    force_ov = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_round_robin();
    test_cap();
    test_err_sync();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
